// File: rtl/usb_rx_dac_feeder.sv
// usb_rx_dac_feeder
// Host->device read path: captures FX3 bus words a fixed latency after each
// SLRD strobe into a circular buffer, unpacks every word into two 14-bit
// offset-binary DAC samples and plays them at a programmable rate. Playback
// re-primes after underrun; rd_pause throttles the stream controller.
module usb_rx_dac_feeder #(
  parameter int DEPTH_LOG2   = 10,
  parameter int RD_LAT       = 2,
  parameter int PRIME_LEVEL  = 256,
  parameter int AFULL_MARGIN = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  slrd_n,
  input  logic [31:0]           fx3_dq,
  input  logic                  enable,
  input  logic [7:0]            rate_div,
  input  logic                  clr_flags,
  output logic [13:0]           dac_data,
  output logic                  dac_valid,
  output logic                  rd_pause,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  underrun,
  output logic                  overflow,
  output logic [1:0]            state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_AFULL = (DEPTH_LOG2+1)'(DEPTH - AFULL_MARGIN);
  localparam logic [DEPTH_LOG2:0] LVL_PRIME = (DEPTH_LOG2+1)'(PRIME_LEVEL);
  localparam logic [13:0]         DAC_MID   = 14'h2000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PRIME = 2'b01,
    S_PLAY  = 2'b10,
    S_UNDER = 2'b11
  } state_t;

  state_t                r_state, w_state_next;
  logic [RD_LAT-1:0]     r_strb;
  logic [31:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [DEPTH_LOG2:0]   r_level, w_level_next;
  logic                  r_rd_pause;
  logic                  r_half;
  logic [7:0]            r_cnt;
  logic [13:0]           r_dac_data, w_dac_next;
  logic                  r_dac_valid;
  logic                  r_underrun, r_overflow;

  logic                  w_push, w_push_ok, w_drop, w_pop;
  logic                  w_tick, w_sample, w_starve, w_leave;
  logic [31:0]           w_head;
  logic                  w_unused_lsbs;

  assign w_push    = r_strb[RD_LAT-1];
  assign w_push_ok = w_push && ((r_level != LVL_FULL) || w_pop);
  assign w_drop    = w_push && !w_push_ok;
  assign w_head    = r_mem[r_rptr];
  assign w_tick    = (r_state == S_PLAY) && (r_cnt >= rate_div);
  // Bits below the DAC resolution in each half-word are discarded.
  assign w_unused_lsbs = ^{w_head[17:16], w_head[1:0]};

  // Strobe delay line: a 1 at the tail marks the cycle fx3_dq carries a read word.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_strb <= '0;
    end else begin
      r_strb[0] <= ~slrd_n;
      for (int i = 1; i < RD_LAT; i++) r_strb[i] <= r_strb[i-1];
    end
  end

  // Buffer storage write port; the show-ahead head is read combinationally.
  // NOTE: the array has no reset; pointers and level define what is valid,
  // and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= fx3_dq;
  end

  // Next buffer level from accepted push and pop.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_level_next = r_level;
    if (w_push_ok && !w_pop)      w_level_next = r_level + 1'b1;
    else if (!w_push_ok && w_pop) w_level_next = r_level - 1'b1;
  end

  // Pointers wrap modulo DEPTH; rd_pause is registered from the next level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_rd_pause <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      r_level    <= w_level_next;
      r_rd_pause <= (w_level_next >= LVL_AFULL);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next state; dropping enable returns to IDLE from anywhere.
  always_comb begin
    w_state_next = r_state;
    if (!enable) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_next = S_PRIME;
        S_PRIME: if (r_level >= LVL_PRIME) w_state_next = S_PLAY;
        S_PLAY:  if (w_tick && !r_half && (r_level == '0)) w_state_next = S_UNDER;
        default: w_state_next = S_PRIME;
      endcase
    end
  end

  // FSM outputs: sample selection, starvation, pops and the next DAC value.
  always_comb begin
    w_sample   = 1'b0;
    w_starve   = 1'b0;
    w_pop      = 1'b0;
    w_leave    = (r_state == S_PLAY) && (w_state_next != S_PLAY);
    w_dac_next = r_dac_data;
    if (w_tick && enable) begin
      if (r_level != '0) begin
        w_sample   = 1'b1;
        w_pop      = r_half;
        w_dac_next = r_half ? w_head[31:18] : w_head[15:2];
      end else if (!r_half) begin
        w_starve = 1'b1;
      end
    end
    // A half-consumed head word is discarded whenever playback stops.
    if (w_leave && r_half) w_pop = 1'b1;
    if (w_state_next != S_PLAY) w_dac_next = DAC_MID;
  end

  // Half selector and sample-rate counter; both idle outside PLAY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_half <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_leave)       r_half <= 1'b0;
      else if (w_sample) r_half <= ~r_half;
      if (r_state != S_PLAY) r_cnt <= '0;
      else if (w_tick)       r_cnt <= '0;
      else                   r_cnt <= r_cnt + 1'b1;
    end
  end

  // DAC output register; dac_valid pulses one clock after the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dac_data  <= DAC_MID;
      r_dac_valid <= 1'b0;
    end else begin
      r_dac_data  <= w_dac_next;
      r_dac_valid <= w_sample;
    end
  end

  // Sticky flags; a set event in the same cycle wins over clr_flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_starve)       r_underrun <= 1'b1;
      else if (clr_flags) r_underrun <= 1'b0;
      if (w_drop)         r_overflow <= 1'b1;
      else if (clr_flags) r_overflow <= 1'b0;
    end
  end

  assign dac_data   = r_dac_data;
  assign dac_valid  = r_dac_valid;
  assign rd_pause   = r_rd_pause;
  assign fifo_level = r_level;
  assign underrun   = r_underrun;
  assign overflow   = r_overflow;
  assign state      = r_state;

endmodule

// File: tb/tb_usb_rx_dac_feeder.sv
// tb_usb_rx_dac_feeder
// Directed scenarios plus a randomized soak, compared each clock against a
// queue-based reference model of the feeder.
`timescale 1ns/1ps
module tb_usb_rx_dac_feeder;

  localparam int DEPTH_LOG2   = 10;
  localparam int RD_LAT       = 2;
  localparam int PRIME_LEVEL  = 256;
  localparam int AFULL_MARGIN = 8;
  localparam int DEPTH        = 1 << DEPTH_LOG2;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_PRIME = 2'b01;
  localparam logic [1:0] ST_PLAY  = 2'b10;
  localparam logic [1:0] ST_UNDER = 2'b11;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                slrd_n = 1'b1;
  logic [31:0]         fx3_dq = '0;
  logic                enable = 1'b0;
  logic [7:0]          rate_div = '0;
  logic                clr_flags = 1'b0;
  logic [13:0]         dac_data;
  logic                dac_valid;
  logic                rd_pause;
  logic [DEPTH_LOG2:0] fifo_level;
  logic                underrun;
  logic                overflow;
  logic [1:0]          state;

  usb_rx_dac_feeder #(
    .DEPTH_LOG2(DEPTH_LOG2), .RD_LAT(RD_LAT),
    .PRIME_LEVEL(PRIME_LEVEL), .AFULL_MARGIN(AFULL_MARGIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .slrd_n(slrd_n), .fx3_dq(fx3_dq),
    .enable(enable), .rate_div(rate_div), .clr_flags(clr_flags),
    .dac_data(dac_data), .dac_valid(dac_valid), .rd_pause(rd_pause),
    .fifo_level(fifo_level), .underrun(underrun), .overflow(overflow),
    .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mq[$];        // buffered words, head at index 0
  bit          strb_hist[$]; // strobes still travelling toward the bus
  logic [1:0]  m_state;
  bit          m_second;     // next sample comes from the high half
  int          m_since;      // clocks since the last rate tick
  logic [13:0] m_dac;
  bit          m_valid, m_pause, m_unf, m_ovf;

  task automatic model_reset();
    mq.delete();
    strb_hist.delete();
    for (int i = 0; i < RD_LAT; i++) strb_hist.push_back(1'b0);
    m_state = ST_IDLE; m_second = 0; m_since = 0;
    m_dac = 14'h2000; m_valid = 0; m_pause = 0; m_unf = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit slrd_low, input logic [31:0] dq, input bit en,
                            input logic [7:0] rd, input bit clr);
    bit push, tick, sample, starve, pop, drop;
    logic [1:0]  nxt;
    logic [31:0] head;
    push   = strb_hist.pop_front();
    strb_hist.push_back(slrd_low);
    head   = (mq.size() > 0) ? mq[0] : 32'h0;
    tick   = (m_state == ST_PLAY) && (m_since >= int'(rd));
    sample = tick && en && (mq.size() > 0);
    starve = tick && en && (mq.size() == 0);
    if (!en) nxt = ST_IDLE;
    else begin
      case (m_state)
        ST_IDLE:  nxt = ST_PRIME;
        ST_PRIME: nxt = (mq.size() >= PRIME_LEVEL) ? ST_PLAY : ST_PRIME;
        ST_PLAY:  nxt = starve ? ST_UNDER : ST_PLAY;
        default:  nxt = ST_PRIME;
      endcase
    end
    m_valid = sample;
    if (sample) m_dac = m_second ? head[31:18] : head[15:2];
    else if (nxt != ST_PLAY) m_dac = 14'h2000;
    pop = (sample && m_second) || (m_state == ST_PLAY && nxt != ST_PLAY && m_second);
    if (pop) void'(mq.pop_front());
    drop = 0;
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(dq);
      else drop = 1;
    end
    if (m_state == ST_PLAY && nxt != ST_PLAY) m_second = 0;
    else if (sample) m_second = !m_second;
    m_since = (m_state == ST_PLAY && !tick) ? m_since + 1 : 0;
    if (starve) m_unf = 1; else if (clr) m_unf = 0;
    if (drop)   m_ovf = 1; else if (clr) m_ovf = 0;
    m_pause = (mq.size() >= DEPTH - AFULL_MARGIN);
    m_state = nxt;
  endtask

  // ---------------- stimulus plumbing ----------------
  int          cyc = 0;
  int          pend_due[$];
  logic [31:0] pend_word[$];
  bit          en_cur = 0;
  logic [7:0]  rd_cur = '0;

  int          n_pulses = 0;
  int          n_first = 0;
  logic [13:0] first_smp [2];
  bit          obs_unf = 0, obs_play = 0, obs_pause = 0;
  int          pause_lvl = -1;

  task automatic compare_outputs();
    check("state",      32'(state),      32'(m_state));
    check("dac_data",   32'(dac_data),   32'(m_dac));
    check("dac_valid",  32'(dac_valid),  32'(m_valid));
    check("rd_pause",   32'(rd_pause),   32'(m_pause));
    check("fifo_level", 32'(fifo_level), 32'(mq.size()));
    check("underrun",   32'(underrun),   32'(m_unf));
    check("overflow",   32'(overflow),   32'(m_ovf));
    if (dac_valid) begin
      n_pulses++;
      if (n_first < 2) begin first_smp[n_first] = dac_data; n_first++; end
    end
    if (underrun) obs_unf = 1;
    if (state == ST_PLAY) obs_play = 1;
    if (rd_pause && !obs_pause) begin obs_pause = 1; pause_lvl = int'(fifo_level); end
  endtask

  task automatic body(input bit s_n, input logic [31:0] word, input bit clr);
    logic [31:0] dq;
    compare_outputs();
    cyc++;
    if (!s_n) begin pend_due.push_back(cyc + RD_LAT); pend_word.push_back(word); end
    dq = $urandom;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      dq = pend_word.pop_front();
      void'(pend_due.pop_front());
    end
    slrd_n = s_n; fx3_dq = dq; enable = en_cur; rate_div = rd_cur; clr_flags = clr;
    model_step(!s_n, dq, en_cur, rd_cur, clr);
  endtask

  task automatic cycle(input bit s_n, input logic [31:0] word, input bit clr);
    @(negedge clk);
    body(s_n, word, clr);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    compare_outputs();
    rst_n = 1'b0; slrd_n = 1'b1; enable = 1'b0; clr_flags = 1'b0;
    #1;
    check("rst_dac_data",  32'(dac_data),   32'h2000);
    check("rst_dac_valid", 32'(dac_valid),  32'h0);
    check("rst_rd_pause",  32'(rd_pause),   32'h0);
    check("rst_level",     32'(fifo_level), 32'h0);
    check("rst_flags",     32'({underrun, overflow}), 32'h0);
    check("rst_state",     32'(state),      32'(ST_IDLE));
    model_reset();
    pend_due.delete(); pend_word.delete();
    en_cur = 0;
    @(negedge clk);
    rst_n = 1'b1;
    body(1'b1, '0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t required < 2ms", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit s_n;
    int play_start;
    model_reset();
    #2 rst_n = 1'b0;

    // 1: reset, then enable with no strobes -> PRIME, mid-scale, empty
    reset_dut();
    en_cur = 1; rd_cur = 8'd3;
    repeat (5) cycle(1'b1, '0, 1'b0);
    check("t1_state", 32'(state), 32'(ST_PRIME));
    check("t1_dac",   32'(dac_data), 32'h2000);
    check("t1_valid", 32'(dac_valid), 32'h0);
    check("t1_level", 32'(fifo_level), 32'h0);

    // 2-4: prime 256 words, play at rate_div=3, drain to underrun
    n_pulses = 0; n_first = 0; obs_unf = 0; obs_play = 0;
    for (int i = 0; i < 256; i++) cycle(1'b0, (i == 0) ? 32'h8004_0008 : $urandom, 1'b0);
    for (int i = 0; i < 4000 && !obs_unf; i++) cycle(1'b1, '0, 1'b0);
    check("t4_underrun_seen", 32'(obs_unf), 32'h1);
    check("t2_play_seen",     32'(obs_play), 32'h1);
    check("t2_first_lo",      32'(first_smp[0]), 32'h0002);
    check("t2_first_hi",      32'(first_smp[1]), 32'h2001);
    check("t4_pulses",        32'(n_pulses), 32'd512);
    check("t4_state_under",   32'(state), 32'(ST_UNDER));
    check("t4_dac_mid",       32'(dac_data), 32'h2000);
    cycle(1'b1, '0, 1'b0);
    check("t4_state_prime",   32'(state), 32'(ST_PRIME));
    cycle(1'b1, '0, 1'b1);
    cycle(1'b1, '0, 1'b0);
    check("t4_underrun_clr",  32'(underrun), 32'h0);

    // 5: enable=0, push 1025 words -> pause at 1016, last word dropped
    reset_dut();
    obs_pause = 0; pause_lvl = -1;
    for (int i = 0; i < 1025; i++) cycle(1'b0, $urandom, 1'b0);
    repeat (5) cycle(1'b1, '0, 1'b0);
    check("t5_pause_level", 32'(pause_lvl), 32'd1016);
    check("t5_level",       32'(fifo_level), 32'd1024);
    check("t5_overflow",    32'(overflow), 32'h1);
    check("t5_rd_pause",    32'(rd_pause), 32'h1);

    // 6: full buffer in PLAY, pushes landing exactly on high-half pops
    cycle(1'b1, '0, 1'b1);
    en_cur = 1; rd_cur = 8'd3;
    play_start = -1;
    for (int i = 0; i < 120; i++) begin
      if (play_start < 0 && m_state == ST_PLAY) play_start = cyc + 1;
      s_n = !(play_start >= 0 && ((cyc + 1 - play_start) % 8 == 5));
      cycle(s_n, $urandom, 1'b0);
    end
    repeat (3) cycle(1'b1, '0, 1'b0);
    check("t6_play_reached", 32'(play_start >= 0), 32'h1);
    check("t6_overflow",     32'(overflow), 32'h0);

    // 7: randomized soak with enable toggles, clears and one mid-stream reset
    en_cur = 1; rd_cur = 8'd2;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        reset_dut();
        en_cur = 1;
      end
      if ($urandom_range(0, 299) == 0) en_cur = !en_cur;
      if (!en_cur && $urandom_range(0, 19) == 0) rd_cur = 8'($urandom_range(0, 7));
      s_n = !(($urandom_range(0, 3) != 0) && !(rd_pause && (i % 1000) < 700) && (i % 1000) < 800);
      cycle(s_n, $urandom, $urandom_range(0, 99) == 0);
    end

    @(negedge clk);
    compare_outputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
